// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store stage in front of the
// 16-word data memory.
package mem_pkg;

  // Default datapath widths
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int OFF_W  = 6;
  localparam int REG_W  = 3;

  // Latency counter width, enough for READ_LAT up to 4
  localparam int CNT_W  = 3;

  // Memory l_s encodings, also the legal request opcodes
  localparam logic [1:0] L_S_IDLE  = 2'b00;
  localparam logic [1:0] L_S_STORE = 2'b01;
  localparam logic [1:0] L_S_LOAD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Only store and load may reach the memory
  function automatic logic op_legal(input logic [1:0] op);
    logic legal;
    case (op)
      L_S_STORE: legal = 1'b1;
      L_S_LOAD:  legal = 1'b1;
      default:   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request / memory / response bundle of the load-store stage.
// slave is the unit's view, master is the view of its surroundings
// (execute, data memory, writeback).
interface mem_access_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int OFF_W  = 6,
  parameter int REG_W  = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_base;
  logic [OFF_W-1:0]  req_off;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_rd;

  logic [1:0]        mem_l_s;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [REG_W-1:0]  resp_rd;
  logic              resp_we;
  logic              resp_fault;

  modport slave (
    input  req_valid, req_op, req_base, req_off, req_wdata, req_rd,
    input  mem_r_data, resp_ready,
    output req_ready, mem_l_s, mem_addr, mem_w_data,
    output resp_valid, resp_data, resp_rd, resp_we, resp_fault
  );

  modport master (
    output req_valid, req_op, req_base, req_off, req_wdata, req_rd,
    output mem_r_data, resp_ready,
    input  req_ready, mem_l_s, mem_addr, mem_w_data,
    input  resp_valid, resp_data, resp_rd, resp_we, resp_fault
  );

endinterface

// File: rtl/mem_ea_calc.sv
// Effective address computation: sign-extend the offset, add it to the
// base with wraparound, and flag out-of-range addresses or illegal ops.
module mem_ea_calc
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] base_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] ea_o,
  output logic              fault_o
);

  logic [DATA_W-1:0] off_ext_s;
  logic [DATA_W-1:0] ea_s;

  // Sign-extend and add; carry-out is dropped so the sum wraps
  always_comb begin
    off_ext_s = {{(DATA_W-OFF_W){off_i[OFF_W-1]}}, off_i};
    ea_s      = base_i + off_ext_s;
  end

  // Any set bit above the word address or an unknown opcode is a fault
  always_comb begin
    fault_o = 1'b0;
    if ((ea_s[DATA_W-1:ADDR_W] != '0) || !op_legal(op_i)) begin
      fault_o = 1'b1;
    end else begin
      fault_o = 1'b0;
    end
  end

  assign ea_o = ea_s;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: accepts one request from execute, drives the data
// memory for one store cycle or READ_LAT load cycles, then holds the
// result for writeback until it is accepted. Faults skip the memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic [1:0]        mem_l_s_q, mem_l_s_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_w_data_q, mem_w_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [REG_W-1:0]  resp_rd_q, resp_rd_d;
  logic              resp_we_q, resp_we_d;
  logic              resp_fault_q, resp_fault_d;

  logic [DATA_W-1:0] ea_s;
  logic              fault_s;
  logic              accept_s;

  mem_ea_calc u_ea_calc (
    .base_i  (bus.req_base),
    .off_i   (bus.req_off),
    .op_i    (bus.req_op),
    .ea_o    (ea_s),
    .fault_o (fault_s)
  );

  assign accept_s = bus.req_valid & req_ready_q;

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_l_s_d    = L_S_IDLE;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_we_d    = resp_we_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          resp_rd_d    = bus.req_rd;
          resp_data_d  = '0;
          resp_we_d    = 1'b0;
          resp_fault_d = fault_s;
          if (fault_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d    = ACCESS;
            cnt_d      = '0;
            mem_l_s_d  = bus.req_op;
            mem_addr_d = ea_s[ADDR_W-1:0];
            if (bus.req_op == L_S_STORE) begin
              mem_w_data_d = bus.req_wdata;
            end else begin
              mem_w_data_d = '0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // mem_l_s_q doubles as the latched opcode while in ACCESS
        if (mem_l_s_q == L_S_LOAD) begin
          if (cnt_q == LAST_CNT) begin
            state_d      = RESP;
            resp_data_d  = bus.mem_r_data;
            resp_we_d    = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            mem_l_s_d = L_S_LOAD;
          end
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      mem_l_s_q    <= L_S_IDLE;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_we_q    <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      mem_l_s_q    <= mem_l_s_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_we_q    <= resp_we_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_l_s    = mem_l_s_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_fault = resp_fault_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage sitting directly upstream of the 16-word data memory in the RISC pipeline. It accepts one load or store request from execute, computes the effective address, and drives the memory's l_s/addr/w_data interface. It captures read data and hands a result to writeback over a valid/ready handshake. It also flags address faults and illegal ops without touching memory.

Parameters:
ADDR_W, 4, memory word-address width (16 words)
DATA_W, 16, data word width
OFF_W, 6, signed immediate offset width
REG_W, 3, destination register index width
READ_LAT, 1, cycles l_s=LOAD is held before read data is captured (1..4)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  execute presents a request
req_ready  out  1  unit can accept (IDLE only)
req_op  in  2  2'b01 store, 2'b10 load, others illegal
req_base  in  DATA_W  base register value
req_off  in  OFF_W  signed offset
req_wdata  in  DATA_W  store data
req_rd  in  REG_W  load destination register
mem_l_s  out  2  to memory: 01 store, 10 load, 00 idle
mem_addr  out  ADDR_W  to memory address
mem_w_data  out  DATA_W  to memory write data
mem_r_data  in  DATA_W  from memory read data
resp_valid  out  1  result available to writeback
resp_ready  in  1  writeback accepts
resp_data  out  DATA_W  load data (0 for store/fault)
resp_rd  out  REG_W  echoed req_rd
resp_we  out  1  1 = writeback must write resp_rd
resp_fault  out  1  1 = address fault or illegal op

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0 while rst high, 1 in first cycle after; mem_l_s=00, mem_addr=0, mem_w_data=0; resp_valid=0, resp_data=0, resp_rd=0, resp_we=0, resp_fault=0; latency counter=0.
- All mem_* and resp_* outputs are registered. mem_l_s is 00 in every state except ACCESS.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/wdata/rd and compute ea = req_base + sign_extend(req_off), modulo 2^DATA_W (wraps, no carry-out).
- Fault: fault when ea[DATA_W-1:ADDR_W] != 0, or op not in {01,10}. On fault go IDLE->RESP directly with resp_fault=1, resp_we=0, resp_data=0. The memory is never driven.
- Otherwise go to ACCESS with mem_addr=ea[ADDR_W-1:0] and mem_l_s=op; for a store, mem_w_data=req_wdata (for a load, mem_w_data=0).
- ACCESS, store: exactly 1 cycle. The memory commits at that cycle's closing edge. Next state RESP with resp_we=0, resp_data=0, resp_fault=0.
- ACCESS, load: held for READ_LAT cycles using a counter. On the closing edge of the last ACCESS cycle, resp_data<=mem_r_data and resp_we=1. Next state RESP.
- RESP: resp_valid=1; all resp_* fields hold stable until resp_ready=1. The handshake completes on the edge where resp_valid&resp_ready; that edge clears resp_valid and returns to IDLE.
- req_ready=0 in ACCESS and RESP, so requests presented then are not accepted and must be held by execute.
- Minimum occupancy is IDLE+ACCESS+RESP = 3 cycles for a load with READ_LAT=1. A fault takes 2 cycles.
- Reset mid-operation: asynchronous return to IDLE with mem_l_s=00 immediately. A store whose ACCESS cycle has not reached its closing edge is abandoned, and no response is issued.
- resp_rd always echoes req_rd, including for stores and faults.

Decomposition:
- Package mem_pkg holds:
  - localparams L_S_IDLE=2'b00, L_S_STORE=2'b01, L_S_LOAD=2'b10.
  - enum state_t {IDLE, ACCESS, RESP}.
  - The ADDR_W/DATA_W defaults.
- One natural sub-module, mem_ea_calc: combinational sign-extend, add, and fault check, outputting ea and fault.

Test Plan:
- Store then load: store req_base=0x0003, req_off=+2, wdata=0xBEEF. Expect mem_l_s=01 and mem_addr=5 for 1 cycle, then resp_we=0. Then load from the same address with req_rd=4: expect resp_data=0xBEEF, resp_rd=4, resp_we=1, resp_fault=0.
- Negative offset wrap: load req_base=0x0001, req_off=-3 (ea=0xFFFE) -> fault. Expect resp_fault=1, resp_we=0, mem_l_s stays 00 throughout.
- Illegal op: req_op=2'b11, base=0, off=0 -> response with resp_fault=1 and no memory access. Also req_op=2'b00 -> same.
- Backpressure: hold resp_ready=0 for 5 cycles after a load. Expect resp_valid and resp_data stable, req_ready=0, and a second req_valid not accepted until one cycle after resp_ready=1.
- READ_LAT=3: load from address 0xF. Expect mem_l_s=10 for exactly 3 cycles and data captured at the end of the third cycle.
- Async reset: assert rst during the ACCESS cycle of a store of 0x1234 to address 7. Expect mem_l_s=00 immediately, word 7 unchanged, no resp_valid, and req_ready=1 one cycle after rst deasserts.
